// File: rtl/dac_multi.sv
`default_nettype none
// ============================================================================
// Module   : dac_multi
// Brief    : Multi-channel 1-bit sigma-delta DAC, first- or second-order.
// Revision : 1.0 - initial release
// ============================================================================
module dac_multi #(
    parameter int CH    = 2,
    parameter int W     = 16,
    parameter int DIV   = 5,
    parameter int ORDER = 1
) (
    input  logic            CLK,
    input  logic            RESET_n,
    input  logic [CH*W-1:0] IN,
    input  logic [CH-1:0]   VALID,
    input  logic [CH-1:0]   MUTE,
    output logic [CH-1:0]   OUT,
    output logic            TICK
);

    localparam logic [7:0] C_RELOAD = 8'(DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       w_tick;

    assign w_tick = (cnt_q == 8'd0);
    // Gated so TICK stays low during reset even when DIV=1 parks the counter at 0.
    assign TICK   = w_tick & RESET_n;

    always_comb begin
        cnt_d = w_tick ? C_RELOAD : (cnt_q - 8'd1);
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt_q <= C_RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic signed [W-1:0] s_q;
        logic signed [W-1:0] x;
        logic                out_q;

        always_ff @(posedge CLK or negedge RESET_n) begin
            if (!RESET_n) begin
                s_q <= '0;
            end else if (w_tick && VALID[k]) begin
                s_q <= IN[k*W +: W];
            end
        end

        assign x      = MUTE[k] ? '0 : s_q;
        assign OUT[k] = out_q;

        if (ORDER == 1) begin : g_o1
            logic [W-1:0] a_q;
            logic [W:0]   sum;

            // Flipping the sign bit maps signed X onto offset binary 0..2^W-1.
            assign sum = {1'b0, a_q} + {1'b0, ~x[W-1], x[W-2:0]};

            always_ff @(posedge CLK or negedge RESET_n) begin
                if (!RESET_n) begin
                    a_q   <= '0;
                    out_q <= 1'b0;
                end else if (w_tick) begin
                    a_q   <= sum[W-1:0];
                    out_q <= sum[W];
                end
            end
        end else begin : g_o2
            localparam int IW = W + 4;
            localparam int EW = W + 6;
            localparam logic signed [EW-1:0] C_MAX = {3'b000, {(IW-1){1'b1}}};
            localparam logic signed [EW-1:0] C_MIN = {3'b111, {(IW-1){1'b0}}};
            localparam logic signed [EW-1:0] C_FBP = {{(EW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
            localparam logic signed [EW-1:0] C_FBN = {{(EW-W+1){1'b1}}, {(W-1){1'b0}}};

            logic signed [IW-1:0] i1_q;
            logic signed [IW-1:0] i2_q;
            logic signed [IW-1:0] i1_d;
            logic signed [IW-1:0] i2_d;
            logic                 q_q;
            logic signed [EW-1:0] fb;
            logic signed [EW-1:0] e1;
            logic signed [EW-1:0] e2;

            // Sums are formed two bits wider so saturation can see the true result.
            always_comb begin
                fb = q_q ? C_FBP : C_FBN;
                e1 = EW'(i1_q) + EW'(x) - fb;
                if (e1 > C_MAX) begin
                    i1_d = C_MAX[IW-1:0];
                end else if (e1 < C_MIN) begin
                    i1_d = C_MIN[IW-1:0];
                end else begin
                    i1_d = e1[IW-1:0];
                end
                e2 = EW'(i2_q) + EW'(i1_d) - fb;
                if (e2 > C_MAX) begin
                    i2_d = C_MAX[IW-1:0];
                end else if (e2 < C_MIN) begin
                    i2_d = C_MIN[IW-1:0];
                end else begin
                    i2_d = e2[IW-1:0];
                end
            end

            always_ff @(posedge CLK or negedge RESET_n) begin
                if (!RESET_n) begin
                    i1_q  <= '0;
                    i2_q  <= '0;
                    q_q   <= 1'b0;
                    out_q <= 1'b0;
                end else if (w_tick) begin
                    i1_q  <= i1_d;
                    i2_q  <= i2_d;
                    q_q   <= ~i2_d[IW-1];
                    out_q <= ~i2_d[IW-1];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/dac_multi.md
DAC_MULTI -- requirements
Module: dac_multi

Interface
REQ-001 SHALL have parameter CH, default 2, number of independent 1-bit DAC channels (legal 1..8).
REQ-002 SHALL have parameter W, default 16, signed two's-complement sample width per channel (legal 4..24).
REQ-003 SHALL have parameter DIV, default 5, modulator update divider; one update tick every DIV CLK cycles (legal 1..255).
REQ-004 SHALL have parameter ORDER, default 1, modulator order; 1 is first-order accumulator, 2 is second-order error-feedback (other values illegal).
REQ-005 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have port RESET_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port IN  input  CH*W  signed samples; channel k at bits [k*W+W-1 : k*W].
REQ-008 SHALL have port VALID  input  CH  per-channel sample-valid; IN channel k is captured only on a tick with VALID[k]=1.
REQ-009 SHALL have port MUTE  input  CH  per-channel mute; forces that channel's modulator input to mid-scale (signed 0).
REQ-010 SHALL have port OUT  output  CH  per-channel 1-bit pulse-density output, registered.
REQ-011 SHALL have port TICK  output  1  high for exactly one CLK cycle per update period.

Function
REQ-012 SHALL implement an 8-bit down-counter: reset value DIV-1; on each edge, reload DIV-1 if 0, else decrement; TICK = (counter==0), combinational from the register.
REQ-013 SHALL, with DIV=1, hold TICK permanently high after reset release.
REQ-014 SHALL hold per-channel sample register S[k] (W bits, reset 0); on an edge with TICK=1 and VALID[k]=1, S[k] <= IN channel k; otherwise S[k] holds.
REQ-015 SHALL feed the modulator the operand X[k] = 0 when MUTE[k]=1, else S[k]; MUTE is sampled combinationally on the tick edge, no ramp.
REQ-016 SHALL use the already-held S[k] (value before the current edge's capture) as modulator input, giving a one-tick latency from capture to modulation.
REQ-017 SHALL, ORDER=1: U = X XOR 2^(W-1) (offset binary, 0..2^W-1); W-bit unsigned accumulator A (reset 0); on tick, sum = A + U (W+1 bits), OUT[k] <= sum[W], A <= sum[W-1:0].
REQ-018 SHALL, ORDER=2: signed W+4-bit integrators I1, I2 (reset 0), stored bit Q (reset 0); FB = +2^(W-1) if Q=1 else -2^(W-1); on tick I1' = I1 + X - FB; I2' = I2 + I1' - FB; Q' = (I2' >= 0); OUT[k] <= Q'.
REQ-019 SHALL saturate I1 and I2 to the signed W+4-bit range instead of wrapping.
REQ-020 SHALL leave OUT, A, I1, I2, Q unchanged on edges where TICK=0.
REQ-021 SHALL process all channels in parallel on the same tick; no channel interacts with another.
REQ-022 SHALL, for ORDER=1, X = +(2^(W-1)-1), produce exactly 2^W-1 ones in every 2^W consecutive ticks once A starts from 0.
REQ-023 SHALL, for ORDER=1, X = -2^(W-1), produce OUT[k]=0 on every tick.

Reset
REQ-024 SHALL, while RESET_n=0, force OUT=0, TICK=0 (counter=DIV-1; TICK=1 only if DIV=1 per REQ-013 after release), all S, A, I1, I2, Q to 0, independent of CLK.
REQ-025 SHALL, on reset assertion mid-period, discard partial counter state; after release the first TICK occurs in the cycle following the (DIV-1)th rising edge and OUT first updates on the DIV-th edge.

Verification
REQ-026 SHALL pass: DIV=5, reset release -> TICK high during cycles 5,10,15... (cycle n = after edge n-1), one cycle wide, no TICK during reset.
REQ-027 SHALL pass: W=4, ORDER=1, IN=0, VALID=1 -> OUT sequence per tick after latency 0,1,0,1,... (A: 8,0,8,0).
REQ-028 SHALL pass: W=4, ORDER=1, IN=+7 -> A sequence 15,14,13,...; exactly 15 ones per 16 ticks; IN=-8 -> OUT constantly 0.
REQ-029 SHALL pass: CH=2, ch0 IN=+7 VALID=1, ch1 VALID=0 throughout -> ch1 S stays 0 and OUT[1] toggles 0,1,0,1; MUTE[0]=1 asserted mid-stream -> ch0 switches to mid-scale density on the next tick.
REQ-030 SHALL pass: W=16, ORDER=2, IN=+32767 for 10^5 ticks -> no integrator overflow past saturation, ones density within 0.1% of 32767/32768·0.5+0.5.
REQ-031 SHALL pass: RESET_n pulsed low for 1 ns between edges mid-period -> OUT, counter, integrators return to reset values immediately; REQ-025 timing holds after release.
